// File: rtl/instruction_dispatch_queue.sv
// rtl/instruction_dispatch_queue.sv - per-lane instruction FIFOs feeding four per-class dispatch slots
// Each class slot picks a lane round-robin among lanes whose FIFO head targets that class.
module instruction_dispatch_queue #(
   parameter int LANES = 2,
   parameter int DEPTH = 4
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic [LANES-1:0]      enable_i,
   input  logic [2*LANES-1:0]    functionalType_i,
   input  logic [LANES-1:0]      isWb_i,
   input  logic [5*LANES-1:0]    wbAddress_i,
   input  logic [7*LANES-1:0]    opCode_i,
   input  logic [16*LANES-1:0]   pOperand_i,
   input  logic [16*LANES-1:0]   sOperand_i,
   output logic [LANES-1:0]      ready_o,
   input  logic [3:0]            unitReady_i,
   output logic [3:0]            unitValid_o,
   output logic [3:0]            unitIsWb_o,
   output logic [19:0]           unitWbAddress_o,
   output logic [27:0]           unitOpCode_o,
   output logic [63:0]           unitPOperand_o,
   output logic [63:0]           unitSOperand_o,
   output logic [11:0]           unitLane_o,
   output logic [15:0]           stallCount_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   // Entry layout: {type[46:45], isWb[44], wbAddress[43:39], opCode[38:32], pOperand[31:16], sOperand[15:0]}
   localparam int EW = 47;

   logic [EW-1:0]    mem [LANES][DEPTH];
   logic [PW-1:0]    head [LANES];
   logic [PW-1:0]    tail [LANES];
   logic [CW-1:0]    count [LANES];
   logic [2:0]       rr_ptr [4];
   logic [EW-1:0]    head_entry [LANES];
   logic [LANES-1:0] push;
   logic [LANES-1:0] pop;
   logic [3:0]       grant;
   logic [3:0]       slot_free;
   logic [2:0]       grant_lane [4];
   logic [EW-3:0]    grant_entry [4];

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         ready_o[l]    = reset_i && (count[l] < CW'(DEPTH));
         push[l]       = enable_i[l] && ready_o[l];
         head_entry[l] = mem[l][head[l]];
      end
   end

   // A lane's head has exactly one class, so at most one slot can pop any given lane.
   always_comb begin
      int k;
      k     = 0;
      grant = '0;
      pop   = '0;
      for (int c = 0; c < 4; c++) begin
         grant_lane[c]  = '0;
         grant_entry[c] = '0;
         slot_free[c]   = !unitValid_o[c] || unitReady_i[c];
         for (int i = 0; i < LANES; i++) begin
            k = (int'(rr_ptr[c]) + i) % LANES;
            if (slot_free[c] && !grant[c] && (count[k] != '0) &&
                (head_entry[k][EW-1 -: 2] == 2'(c))) begin
               grant[c]       = 1'b1;
               grant_lane[c]  = 3'(k);
               grant_entry[c] = head_entry[k][EW-3:0];
               pop[k]         = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock_i) begin
      for (int l = 0; l < LANES; l++) begin
         if (push[l]) begin
            mem[l][tail[l]] <= {functionalType_i[2*l +: 2], isWb_i[l], wbAddress_i[5*l +: 5],
                                opCode_i[7*l +: 7], pOperand_i[16*l +: 16], sOperand_i[16*l +: 16]};
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         for (int l = 0; l < LANES; l++) begin
            head[l]  <= '0;
            tail[l]  <= '0;
            count[l] <= '0;
         end
      end else begin
         for (int l = 0; l < LANES; l++) begin
            if (push[l]) tail[l] <= tail[l] + PW'(1);
            if (pop[l])  head[l] <= head[l] + PW'(1);
            if (push[l] && !pop[l])      count[l] <= count[l] + CW'(1);
            else if (!push[l] && pop[l]) count[l] <= count[l] - CW'(1);
         end
      end
   end

   // Idle slots drop valid but keep their last data so downstream sees no spurious toggles.
   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         unitValid_o     <= '0;
         unitIsWb_o      <= '0;
         unitWbAddress_o <= '0;
         unitOpCode_o    <= '0;
         unitPOperand_o  <= '0;
         unitSOperand_o  <= '0;
         unitLane_o      <= '0;
         for (int c = 0; c < 4; c++) rr_ptr[c] <= '0;
      end else begin
         for (int c = 0; c < 4; c++) begin
            if (grant[c]) begin
               unitValid_o[c]           <= 1'b1;
               unitIsWb_o[c]            <= grant_entry[c][44];
               unitWbAddress_o[c*5 +: 5] <= grant_entry[c][43:39];
               unitOpCode_o[c*7 +: 7]    <= grant_entry[c][38:32];
               unitPOperand_o[c*16 +: 16] <= grant_entry[c][31:16];
               unitSOperand_o[c*16 +: 16] <= grant_entry[c][15:0];
               unitLane_o[c*3 +: 3]      <= grant_lane[c];
               rr_ptr[c]                <= 3'((int'(grant_lane[c]) + 1) % LANES);
            end else if (slot_free[c]) begin
               unitValid_o[c] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         stallCount_o <= '0;
      end else if (|(enable_i & ~ready_o) && (stallCount_o != 16'hFFFF)) begin
         stallCount_o <= stallCount_o + 16'd1;
      end
   end

endmodule

// File: tb/tb_instruction_dispatch_queue.sv
// tb/tb_instruction_dispatch_queue.sv - directed and random checks against a queue-based dispatch model
module tb_instruction_dispatch_queue;

   localparam int LANES = 2;
   localparam int DEPTH = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [LANES-1:0]    en;
   logic [2*LANES-1:0]  ftype;
   logic [LANES-1:0]    iswb;
   logic [5*LANES-1:0]  wba;
   logic [7*LANES-1:0]  opc;
   logic [16*LANES-1:0] popnd;
   logic [16*LANES-1:0] sopnd;
   logic [3:0]          ur;
   logic [LANES-1:0]    ready;
   logic [3:0]          uvalid;
   logic [3:0]          uiswb;
   logic [19:0]         uwba;
   logic [27:0]         uop;
   logic [63:0]         up;
   logic [63:0]         us;
   logic [11:0]         ulane;
   logic [15:0]         stall;

   always #5 clk = ~clk;

   instruction_dispatch_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
      .clock_i(clk), .reset_i(rst_n), .enable_i(en), .functionalType_i(ftype),
      .isWb_i(iswb), .wbAddress_i(wba), .opCode_i(opc), .pOperand_i(popnd), .sOperand_i(sopnd),
      .ready_o(ready), .unitReady_i(ur), .unitValid_o(uvalid), .unitIsWb_o(uiswb),
      .unitWbAddress_o(uwba), .unitOpCode_o(uop), .unitPOperand_o(up), .unitSOperand_o(us),
      .unitLane_o(ulane), .stallCount_o(stall)
   );

   typedef struct packed {
      logic [1:0]  typ;
      logic        wb;
      logic [4:0]  wa;
      logic [6:0]  op;
      logic [15:0] p;
      logic [15:0] s;
   } ent_t;

   ent_t             mq [LANES][$];
   ent_t             ms [4];
   logic             mv [4];
   int               ml [4];
   int               mrr [4];
   int               mstall;
   logic [LANES-1:0] macc;
   int               errors = 0;
   int               checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int l, input logic e, input logic [1:0] t);
      en[l]             = e;
      ftype[2*l +: 2]   = t;
      iswb[l]           = 1'($urandom);
      wba[5*l +: 5]     = 5'($urandom);
      opc[7*l +: 7]     = 7'($urandom);
      popnd[16*l +: 16] = 16'($urandom);
      sopnd[16*l +: 16] = 16'($urandom);
   endtask

   function automatic ent_t lane_ent(input int l);
      ent_t e;
      e.typ = ftype[2*l +: 2];
      e.wb  = iswb[l];
      e.wa  = wba[5*l +: 5];
      e.op  = opc[7*l +: 7];
      e.p   = popnd[16*l +: 16];
      e.s   = sopnd[16*l +: 16];
      return e;
   endfunction

   // Reference: per-lane queues, slots refilled from the first matching head in rotating lane order.
   task automatic model_step();
      logic [LANES-1:0] mready;
      int gl [4];
      for (int l = 0; l < LANES; l++) mready[l] = rst_n && (mq[l].size() < DEPTH);
      macc = '0;
      if (!rst_n) begin
         for (int l = 0; l < LANES; l++) mq[l].delete();
         for (int c = 0; c < 4; c++) begin
            ms[c] = '0; mv[c] = 1'b0; ml[c] = 0; mrr[c] = 0;
         end
         mstall = 0;
         return;
      end
      if ((|(en & ~mready)) && mstall < 65535) mstall++;
      for (int c = 0; c < 4; c++) begin
         gl[c] = -1;
         if (!mv[c] || ur[c]) begin
            for (int i = 0; i < LANES; i++) begin
               int k = (mrr[c] + i) % LANES;
               if (gl[c] < 0 && mq[k].size() > 0 && mq[k][0].typ == 2'(c)) gl[c] = k;
            end
            if (gl[c] >= 0) begin
               ms[c]  = mq[gl[c]][0];
               ml[c]  = gl[c];
               mv[c]  = 1'b1;
               mrr[c] = (gl[c] + 1) % LANES;
            end else begin
               mv[c] = 1'b0;
            end
         end
      end
      for (int c = 0; c < 4; c++) if (gl[c] >= 0) void'(mq[gl[c]].pop_front());
      for (int l = 0; l < LANES; l++) begin
         if (en[l] && mready[l]) begin
            mq[l].push_back(lane_ent(l));
            macc[l] = 1'b1;
         end
      end
   endtask

   task automatic check_all();
      logic [3:0] ev, ewb;
      logic [19:0] ewa;
      logic [27:0] eop;
      logic [63:0] ep, es;
      logic [11:0] el;
      logic [LANES-1:0] er;
      for (int c = 0; c < 4; c++) begin
         ev[c] = mv[c];
         ewb[c] = ms[c].wb;
         ewa[c*5 +: 5] = ms[c].wa;
         eop[c*7 +: 7] = ms[c].op;
         ep[c*16 +: 16] = ms[c].p;
         es[c*16 +: 16] = ms[c].s;
         el[c*3 +: 3] = 3'(ml[c]);
      end
      for (int l = 0; l < LANES; l++) er[l] = rst_n && (mq[l].size() < DEPTH);
      chk("unit_valid", 64'(uvalid), 64'(ev));
      chk("unit_iswb", 64'(uiswb), 64'(ewb));
      chk("unit_wbaddr", 64'(uwba), 64'(ewa));
      chk("unit_opcode", 64'(uop), 64'(eop));
      chk("unit_pop", up, ep);
      chk("unit_sop", us, es);
      chk("unit_lane", 64'(ulane), 64'(el));
      chk("ready", 64'(ready), 64'(er));
      chk("stall_count", 64'(stall), 64'(mstall));
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      int   obs_lane [$];
      int   idx;
      logic [6:0] op0;
      logic [6:0] opc_c;

      rst_n = 1'b0; en = '0; ftype = '0; iswb = '0; wba = '0; opc = '0;
      popnd = '0; sopnd = '0; ur = 4'hF;

      // Reset state, with a push attempt that must be ignored
      drive(0, 1'b1, 2'd0);
      cycle();
      cycle();
      chk("reset_ready", 64'(ready), 64'd0);
      chk("reset_valid", 64'(uvalid), 64'd0);

      // Single arith push from lane 0 appears one edge later
      rst_n = 1'b1;
      drive(0, 1'b1, 2'd0);
      opc[6:0] = 7'h05;
      cycle();
      en = '0;
      cycle();
      chk("lat_valid0", 64'(uvalid[0]), 64'd1);
      chk("lat_opcode0", 64'(uop[6:0]), 64'h05);
      chk("lat_lane0", 64'(ulane[2:0]), 64'd0);
      repeat (2) cycle();

      // Both lanes stream branches: grants alternate
      for (int n = 0; n < 8; n++) begin
         drive(0, 1'b1, 2'd2);
         drive(1, 1'b1, 2'd2);
         cycle();
         if (uvalid[2]) obs_lane.push_back(int'(ulane[8:6]));
      end
      en = '0;
      for (int n = 0; n < 12; n++) begin
         cycle();
         if (uvalid[2]) obs_lane.push_back(int'(ulane[8:6]));
      end
      chk("alt_count_min", 64'(obs_lane.size() >= 8), 64'd1);
      for (int i = 0; i < 8 && i < obs_lane.size(); i++) chk("alt_lane", 64'(obs_lane[i]), 64'(i % 2));

      // Load-store unit stalled: one held in slot, four queued, sixth stalls
      ur = 4'b1101;
      idx = 0;
      drive(1, 1'b1, 2'd1);
      op0 = opc[13:7];
      for (int n = 0; n < 10; n++) begin
         en[1] = (idx < 6);
         cycle();
         if (macc[1]) begin
            idx++;
            drive(1, idx < 6, 2'd1);
         end
      end
      chk("hold_accepted", 64'(idx), 64'd5);
      chk("hold_ready1", 64'(ready[1]), 64'd0);
      chk("hold_valid1", 64'(uvalid[1]), 64'd1);
      chk("hold_opcode1", 64'(uop[13:7]), 64'(op0));
      en = '0; ur = 4'hF;
      repeat (8) cycle();

      // Blocked load-store head must not let a later arith bypass it
      ur = 4'b1101;
      drive(0, 1'b1, 2'd1); cycle();
      drive(0, 1'b1, 2'd1); cycle();
      drive(0, 1'b1, 2'd0); opc_c = opc[6:0]; cycle();
      en = '0;
      for (int n = 0; n < 4; n++) begin
         cycle();
         chk("nobypass_valid0", 64'(uvalid[0]), 64'd0);
      end
      ur = 4'hF;
      cycle();
      cycle();
      chk("drain_valid0", 64'(uvalid[0]), 64'd1);
      chk("drain_opcode0", 64'(uop[6:0]), 64'(opc_c));
      repeat (3) cycle();

      // Reset mid-operation
      ur = 4'h0;
      for (int n = 0; n < 3; n++) begin
         drive(0, 1'b1, 2'($urandom));
         drive(1, 1'b1, 2'($urandom));
         cycle();
      end
      rst_n = 1'b0;
      cycle();
      chk("midrst_ready", 64'(ready), 64'd0);
      chk("midrst_valid", 64'(uvalid), 64'd0);
      chk("midrst_stall", 64'(stall), 64'd0);
      rst_n = 1'b1; en = '0; ur = 4'hF;
      for (int n = 0; n < 4; n++) begin
         cycle();
         chk("midrst_no_stale", 64'(uvalid), 64'd0);
      end

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         for (int l = 0; l < LANES; l++) drive(l, 1'($urandom), 2'($urandom));
         ur = 4'($urandom);
         cycle();
      end

      // Saturation of the stall counter under continuous stall
      rst_n = 1'b0; en = '0;
      cycle();
      rst_n = 1'b1; ur = 4'b1101;
      drive(0, 1'b1, 2'd1);
      for (int n = 0; n < 65600; n++) cycle();
      chk("stall_saturated", 64'(stall), 64'hFFFF);
      cycle();
      chk("stall_hold", 64'(stall), 64'hFFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instruction_dispatch_queue.md
INSTRUCTION_DISPATCH_QUEUE -- requirements
Module: instruction_dispatch_queue

Interface
REQ-001 Parameter LANES, default 2, number of issue lanes (1..8).
REQ-002 Parameter DEPTH, default 4, entries per lane queue (power of two, >=2).
REQ-003 Class index c: 0 = arith, 1 = load-store, 2 = branch, 3 = reg; lane L occupies bit slice L of every packed per-lane vector.
REQ-004 clock_i  in  1  single clock, all state updates on rising edge.
REQ-005 reset_i  in  1  synchronous reset, active-low.
REQ-006 enable_i  in  LANES  per-lane instruction valid.
REQ-007 functionalType_i  in  2*LANES  per-lane class index.
REQ-008 isWb_i  in  LANES; wbAddress_i  in  5*LANES; opCode_i  in  7*LANES  per-lane instruction fields.
REQ-009 pOperand_i, sOperand_i  in  16*LANES each  per-lane primary/secondary operands.
REQ-010 ready_o  out  LANES  per-lane queue can accept this cycle.
REQ-011 unitReady_i  in  4  per-class unit accepts output this cycle.
REQ-012 unitValid_o  out  4  per-class output holds an instruction.
REQ-013 unitIsWb_o  out  4; unitWbAddress_o  out  20; unitOpCode_o  out  28  per-class fields, slice c.
REQ-014 unitPOperand_o, unitSOperand_o  out  64 each  per-class operands, slice c.
REQ-015 unitLane_o  out  12  per-class 3-bit source lane id.
REQ-016 stallCount_o  out  16  saturating count of upstream stall cycles.

Function
REQ-017 Each lane SHALL own a FIFO of DEPTH entries {type, isWb, wbAddress, opCode, pOperand, sOperand} with occupancy count 0..DEPTH.
REQ-018 ready_o[L] SHALL be high iff reset_i is high and count[L] < DEPTH; it SHALL NOT depend on a same-cycle pop.
REQ-019 Push: enable_i[L] && ready_o[L] SHALL write the lane fields at the tail on the rising edge; enable_i[L] with ready_o[L] low SHALL be ignored (upstream holds).
REQ-020 Output slot c SHALL be free when unitValid_o[c] is low or unitReady_i[c] is high.
REQ-021 For each free slot c, arbitration SHALL select among lanes whose FIFO is non-empty and whose head type equals c, searching round-robin starting at rrPtr[c].
REQ-022 On grant to lane k: head SHALL be popped, entry and lane id k registered into slot c, unitValid_o[c] set, rrPtr[c] <= (k+1) mod LANES.
REQ-023 Free slot with no eligible lane: unitValid_o[c] SHALL clear, data outputs hold last value, rrPtr[c] unchanged.
REQ-024 Non-free slot (valid && !unitReady_i): slot SHALL hold all fields stable; no pop for class c.
REQ-025 Per-lane order SHALL be preserved; no ordering guarantee between lanes; one lane SHALL pop at most one entry per cycle.
REQ-026 Head of a lane targeting a busy class SHALL block that lane (no bypass of later entries).
REQ-027 Latency: entry pushed at edge t into an empty lane with free slot SHALL appear on unitValid_o at edge t+1; sustained throughput one entry per class per cycle.
REQ-028 Simultaneous push and pop on a lane SHALL leave count unchanged; pointers wrap mod DEPTH.
REQ-029 stallCount_o SHALL increment by 1 in each cycle where any lane has enable_i high and ready_o low, saturating at 16'hFFFF.
REQ-030 Four classes SHALL be arbitrated independently and concurrently in one cycle.

Reset
REQ-031 reset_i low at a rising edge SHALL clear all counts, FIFO pointers, rrPtr to 0, unitValid_o to 0, all unit data/lane outputs to 0, stallCount_o to 0.
REQ-032 Reset mid-operation SHALL discard all queued and slotted instructions; pushes during reset SHALL be ignored.
REQ-033 First push SHALL be accepted on the first rising edge with reset_i high.

Verification
REQ-034 LANES=2: lane0 push arith opCode 7'h05, all unitReady_i high -> next edge unitValid_o[0]=1, opCode slice 0 = 7'h05, unitLane_o slice 0 = 0.
REQ-035 Both lanes push branch every cycle, unitReady_i[2]=1 -> grants alternate lane 0,1,0,1; each lane order intact.
REQ-036 unitReady_i[1]=0, lane1 pushes 5 load-stores with DEPTH=4 -> one held in slot, ready_o[1] low once count=4, stallCount_o increments each stalled cycle, fields stable.
REQ-037 Lane0 head load-store blocked, next entry arith -> arith not dispatched until load-store drains (no bypass).
REQ-038 Queues partly full, reset_i low one cycle -> all unitValid_o=0, ready_o=0 during reset, stallCount_o=0, no stale entry emitted afterwards.
REQ-039 stallCount_o forced to 16'hFFFE with continuous stall -> reaches 16'hFFFF and holds.
